// File: rtl/multdiv_sched_pkg.sv
// Shared types and constants for the multiply/divide scheduler.
package multdiv_sched_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    localparam int unsigned DEF_TIMEOUT    = 64;
    localparam int unsigned DEF_STATUS_REG = 30;
    localparam int unsigned DEF_EXC_MULT   = 4;
    localparam int unsigned DEF_EXC_DIV    = 5;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic              op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_W-1:0]  rd;
    } md_req_t;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } md_wb_t;

endpackage

// File: rtl/multdiv_sched_md_timeout_counter.sv
// Cycle counter bounding how long the scheduler waits on the unit; holds at
// its terminal count so the flag stays asserted until the next clear.
module multdiv_sched_md_timeout_counter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_c = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !tc_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multdiv_sched.sv
// Sequences one MULT/DIV operation at a time through the shared iterative
// unit and returns its result (or an rstatus exception) on a writeback port.
module multdiv_sched
    import multdiv_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned STATUS_REG = DEF_STATUS_REG,
    parameter int unsigned EXC_MULT   = DEF_EXC_MULT,
    parameter int unsigned EXC_DIV    = DEF_EXC_DIV
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy
);

    state_e  state_q, state_d;
    md_req_t req_q, req_d;
    md_wb_t  wb_q, wb_d;
    logic    ctrl_mult_q, ctrl_mult_d;
    logic    ctrl_div_q, ctrl_div_d;
    logic    req_ready_q, req_ready_d;
    logic    busy_q, busy_d;
    logic    wb_valid_q, wb_valid_d;

    logic        cnt_clear;
    logic        cnt_enable;
    logic        timeout_c;
    logic [31:0] exc_code;

    assign cnt_clear  = (state_q == ST_START);
    assign cnt_enable = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    assign exc_code   = (req_q.op == OP_DIV) ? DATA_W'(EXC_DIV) : DATA_W'(EXC_MULT);

    multdiv_sched_md_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_md_timeout_counter (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (cnt_clear),
        .enable_i (cnt_enable),
        .tc_c     (timeout_c)
    );

    // Next-state, latch and registered-output logic.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        wb_d        = wb_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    req_d.op    = req_op;
                    req_d.a     = req_a;
                    req_d.b     = req_b;
                    req_d.rd    = req_rd;
                    ctrl_mult_d = (req_op == OP_MULT);
                    ctrl_div_d  = (req_op == OP_DIV);
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                state_d = flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving with the flush has already retired the unit.
                if (flush) begin
                    state_d = md_resultRDY ? ST_IDLE : ST_DRAIN;
                end else if (md_resultRDY) begin
                    if (md_exception) begin
                        wb_d.rd   = REG_W'(STATUS_REG);
                        wb_d.data = exc_code;
                    end else begin
                        wb_d.rd   = req_q.rd;
                        wb_d.data = md_result;
                    end
                    state_d = ST_DONE;
                end else if (timeout_c) begin
                    wb_d.rd   = REG_W'(STATUS_REG);
                    wb_d.data = exc_code;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (md_resultRDY || timeout_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        wb_valid_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            wb_q        <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wb_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            wb_q        <= wb_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            wb_valid_q  <= wb_valid_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign busy         = busy_q;
    assign md_operandA  = req_q.a;
    assign md_operandB  = req_q.b;
    assign md_ctrl_MULT = ctrl_mult_q;
    assign md_ctrl_DIV  = ctrl_div_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_q.rd;
    assign wb_data      = wb_q.data;

endmodule

// File: tb/tb_multdiv_sched.sv
// Directed bench for multdiv_sched with a behavioural 32-cycle mult/div unit.
module tb_multdiv_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [4:0]  req_rd = '0;
    logic        flush = 1'b0;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    multdiv_sched dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_rd       (req_rd),
        .flush        (flush),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_ctrl_MULT (md_ctrl_MULT),
        .md_ctrl_DIV  (md_ctrl_DIV),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Behavioural unit: RDY pulses 32 cycles after the start pulse; unaffected by DUT reset.
    logic        unit_en = 1'b1;
    logic        unit_busy = 1'b0;
    logic [5:0]  unit_cnt = '0;
    logic        unit_op = 1'b0;
    logic [31:0] unit_a = '0;
    logic [31:0] unit_b = '0;

    always @(posedge clock) begin
        if (md_ctrl_MULT || md_ctrl_DIV) begin
            unit_busy <= 1'b1;
            unit_cnt  <= 6'd31;
            unit_op   <= md_ctrl_DIV;
            unit_a    <= md_operandA;
            unit_b    <= md_operandB;
        end else if (unit_busy) begin
            if (unit_cnt == 6'd0) unit_busy <= 1'b0;
            else                  unit_cnt  <= unit_cnt - 6'd1;
        end
    end

    assign md_resultRDY = unit_en && unit_busy && (unit_cnt == 6'd0);
    assign md_exception = unit_op && (unit_b == 32'd0);

    always_comb begin
        if (unit_op) md_result = (unit_b == 32'd0) ? 32'd0 : unit_a / unit_b;
        else         md_result = unit_a * unit_b;
    end

    int mult_pulses = 0;
    int div_pulses  = 0;
    always @(negedge clock) begin
        if (md_ctrl_MULT) mult_pulses++;
        if (md_ctrl_DIV)  div_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Presents a request for one accepted edge; returns sampled in the START cycle.
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
        step(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_wb(input int max_cycles, output int lat, output bit ok);
        lat = 0;
        while (lat < max_cycles && wb_valid !== 1'b1) begin
            step(1);
            lat++;
        end
        ok = (wb_valid === 1'b1);
    endtask

    task automatic ack_wb();
        wb_ready = 1'b1;
        step(1);
        wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        step(2);
        checks++;
        if ({req_ready, busy, wb_valid, md_ctrl_MULT, md_ctrl_DIV} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/busy/wbv/mul/div=%b, want 10000",
                     {req_ready, busy, wb_valid, md_ctrl_MULT, md_ctrl_DIV});
        end
        checks++;
        if ({md_operandA, md_operandB, wb_rd, wb_data} !== 101'd0) begin
            errors++;
            $display("FAIL reset_data: got A=%0h B=%0h rd=%0d data=%0h, want all 0",
                     md_operandA, md_operandB, wb_rd, wb_data);
        end
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_mult();
        int lat; bit ok; int base;
        base = mult_pulses;
        issue(1'b0, 32'd6, 32'd7, 5'd5);
        checks++;
        if ({md_ctrl_MULT, md_ctrl_DIV, busy, req_ready} !== 4'b1010) begin
            errors++;
            $display("FAIL mult_start: got mul/div/busy/rdy=%b, want 1010",
                     {md_ctrl_MULT, md_ctrl_DIV, busy, req_ready});
        end
        checks++;
        if (md_operandA !== 32'd6 || md_operandB !== 32'd7) begin
            errors++;
            $display("FAIL mult_operands: got A=%0d B=%0d, want 6 7", md_operandA, md_operandB);
        end
        wait_wb(100, lat, ok);
        checks++;
        if (!ok || lat != 33) begin
            errors++;
            $display("FAIL mult_latency: got ok=%0d cycles=%0d, want ok=1 cycles=33", ok, lat);
        end
        checks++;
        if (wb_rd !== 5'd5 || wb_data !== 32'd42) begin
            errors++;
            $display("FAIL mult_wb: got rd=%0d data=%0d, want rd=5 data=42", wb_rd, wb_data);
        end
        checks++;
        if (mult_pulses - base != 1) begin
            errors++;
            $display("FAIL mult_pulses: got %0d start pulses, want 1", mult_pulses - base);
        end
        ack_wb();
        checks++;
        if ({req_ready, wb_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL mult_release: got rdy/wbv/busy=%b, want 100", {req_ready, wb_valid, busy});
        end
    endtask

    task automatic test_div();
        int lat; bit ok; int base;
        base = div_pulses;
        issue(1'b1, 32'd100, 32'd0, 5'd8);
        checks++;
        if ({md_ctrl_MULT, md_ctrl_DIV} !== 2'b01) begin
            errors++;
            $display("FAIL div_start: got mul/div=%b, want 01", {md_ctrl_MULT, md_ctrl_DIV});
        end
        wait_wb(100, lat, ok);
        checks++;
        if (!ok || wb_rd !== 5'd30 || wb_data !== 32'd5) begin
            errors++;
            $display("FAIL div_by_zero: got ok=%0d rd=%0d data=%0d, want ok=1 rd=30 data=5",
                     ok, wb_rd, wb_data);
        end
        ack_wb();
        issue(1'b1, 32'd100, 32'd7, 5'd8);
        wait_wb(100, lat, ok);
        checks++;
        if (!ok || lat != 33 || wb_rd !== 5'd8 || wb_data !== 32'd14) begin
            errors++;
            $display("FAIL div_result: got ok=%0d lat=%0d rd=%0d data=%0d, want 1 33 8 14",
                     ok, lat, wb_rd, wb_data);
        end
        checks++;
        if (div_pulses - base != 2) begin
            errors++;
            $display("FAIL div_pulses: got %0d, want 2", div_pulses - base);
        end
        ack_wb();
    endtask

    task automatic test_backpressure();
        int lat; bit ok;
        issue(1'b0, 32'd10, 32'd20, 5'd3);
        wait_wb(100, lat, ok);
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_a     = 32'd1;
        req_b     = 32'd1;
        req_rd    = 5'd9;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if ({wb_valid, req_ready, wb_rd, wb_data} !== {1'b1, 1'b0, 5'd3, 32'd200}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got wbv=%b rdy=%b rd=%0d data=%0d, want 1 0 3 200",
                         i, wb_valid, req_ready, wb_rd, wb_data);
            end
        end
        req_valid = 1'b0;
        ack_wb();
        checks++;
        if ({req_ready, busy, wb_valid} !== 3'b100) begin
            errors++;
            $display("FAIL bp_release: got rdy/busy/wbv=%b, want 100", {req_ready, busy, wb_valid});
        end
    endtask

    task automatic test_flush_wait();
        int n; bit seen; int lat; bit ok;
        issue(1'b0, 32'd5, 32'd5, 5'd4);
        step(5);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        checks++;
        if ({busy, req_ready, wb_valid} !== 3'b100) begin
            errors++;
            $display("FAIL flush_drain: got busy/rdy/wbv=%b, want 100", {busy, req_ready, wb_valid});
        end
        n = 6;
        seen = 1'b0;
        while (req_ready !== 1'b1 && n < 200) begin
            step(1);
            n++;
            if (wb_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (n != 33 || seen) begin
            errors++;
            $display("FAIL flush_exit: got idle at cycle %0d wb_seen=%0d, want 33 0", n, seen);
        end
        issue(1'b0, 32'd3, 32'd3, 5'd2);
        wait_wb(100, lat, ok);
        checks++;
        if (!ok || wb_rd !== 5'd2 || wb_data !== 32'd9) begin
            errors++;
            $display("FAIL flush_next: got ok=%0d rd=%0d data=%0d, want 1 2 9", ok, wb_rd, wb_data);
        end
        ack_wb();
    endtask

    task automatic test_flush_edges();
        int lat; bit ok; bit seen;
        // Flush coincident with RDY must go straight to IDLE.
        issue(1'b0, 32'd4, 32'd4, 5'd7);
        step(32);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        checks++;
        if ({req_ready, wb_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL flush_rdy: got rdy/wbv/busy=%b, want 100", {req_ready, wb_valid, busy});
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (wb_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_rdy_quiet: got activity after flush, want none");
        end
        req_valid = 1'b1;
        flush     = 1'b1;
        step(1);
        checks++;
        if ({req_ready, busy, md_ctrl_MULT} !== 3'b100) begin
            errors++;
            $display("FAIL flush_idle: got rdy/busy/mul=%b, want 100", {req_ready, busy, md_ctrl_MULT});
        end
        req_valid = 1'b0;
        flush     = 1'b0;
        issue(1'b0, 32'd2, 32'd2, 5'd1);
        wait_wb(100, lat, ok);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        checks++;
        if (!ok || {wb_valid, req_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL flush_done: got ok=%0d wbv/rdy/busy=%b, want 1 010",
                     ok, {wb_valid, req_ready, busy});
        end
    endtask

    task automatic test_timeout();
        int lat; bit ok; int n; bit seen;
        unit_en = 1'b0;
        issue(1'b0, 32'd9, 32'd9, 5'd6);
        wait_wb(200, lat, ok);
        checks++;
        if (!ok || lat != 65) begin
            errors++;
            $display("FAIL timeout_latency: got ok=%0d cycles=%0d, want 1 65", ok, lat);
        end
        checks++;
        if (wb_rd !== 5'd30 || wb_data !== 32'd4) begin
            errors++;
            $display("FAIL timeout_wb: got rd=%0d data=%0d, want 30 4", wb_rd, wb_data);
        end
        ack_wb();
        issue(1'b1, 32'd9, 32'd9, 5'd6);
        step(5);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        n = 6;
        seen = 1'b0;
        while (req_ready !== 1'b1 && n < 300) begin
            step(1);
            n++;
            if (wb_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (n != 65 || seen) begin
            errors++;
            $display("FAIL timeout_flush: got idle at cycle %0d wb_seen=%0d, want 65 0", n, seen);
        end
        unit_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit seen;
        issue(1'b0, 32'd8, 32'd8, 5'd9);
        step(10);
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, busy, wb_valid, md_ctrl_MULT, md_ctrl_DIV} !== 5'b10000 ||
            md_operandA !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: got rdy/busy/wbv/mul/div=%b A=%0d, want 10000 A=0",
                     {req_ready, busy, wb_valid, md_ctrl_MULT, md_ctrl_DIV}, md_operandA);
        end
        step(1);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 34; i++) begin
            step(1);
            if (wb_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_stale_rdy: got wb_valid/busy after stale RDY, want none");
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_backpressure();
        test_flush_wait();
        test_flush_edges();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_sched.md
Name: multdiv_sched

Overview:
Sequences the shared iterative multiply/divide unit on behalf of the processor. Accepts one MULT/DIV request at a time and latches the operands. Pulses the unit's start control, then waits for its ready flag or a timeout. Returns the result, or an rstatus exception write, via a valid/ready writeback port; the processor stalls on req_ready low.

Parameters:
TIMEOUT, 64, max cycles in WAIT/DRAIN before forced completion (must exceed unit latency, ~33)
STATUS_REG, 30, destination register for exception writeback
EXC_MULT, 4, rstatus code for multiply overflow/timeout
EXC_DIV, 5, rstatus code for divide-by-zero/timeout

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  processor issues op
req_ready  out  1  scheduler can accept (IDLE only)
req_op  in  1  0=MULT, 1=DIV
req_a  in  32  operand A (dividend/multiplicand)
req_b  in  32  operand B
req_rd  in  5  destination register
flush  in  1  discard in-flight op (branch/jump squash)
md_operandA  out  32  to unit, held stable from START through WAIT
md_operandB  out  32  to unit, held stable from START through WAIT
md_ctrl_MULT  out  1  one-cycle start pulse
md_ctrl_DIV  out  1  one-cycle start pulse
md_result  in  32  unit result
md_exception  in  1  unit exception flag
md_resultRDY  in  1  unit done
wb_valid  out  1  writeback available
wb_ready  in  1  processor accepts writeback
wb_rd  out  5  writeback register
wb_data  out  32  writeback data
busy  out  1  high in any state except IDLE

Behaviour:
- States: IDLE, START, WAIT, DONE, DRAIN.
- Reset (reset=0, async): state=IDLE, all outputs 0 except req_ready=1; operand/op/rd registers and timeout counter cleared.
- Reset mid-operation: immediate abort to IDLE; unit's late md_resultRDY is ignored because RDY is sampled only in WAIT/DRAIN.
- IDLE: req_ready=1. On req_valid: latch op/a/b/rd; go START.
- START (1 cycle): assert md_ctrl_MULT or md_ctrl_DIV per op; clear counter; go WAIT. md_resultRDY ignored this cycle.
- WAIT: counter increments each cycle.
  - md_resultRDY=1 and md_exception=0: register wb_rd=rd, wb_data=md_result.
  - md_resultRDY=1 and md_exception=1: register wb_rd=STATUS_REG, wb_data=EXC_MULT or EXC_DIV (zero-extended).
  - Counter reaches TIMEOUT-1 without RDY: register wb_rd=STATUS_REG, wb_data=EXC_MULT/EXC_DIV.
  - Any of the three cases: go DONE.
- Latency: accept at edge T; start pulse in cycle T+1; RDY seen in cycle R gives wb_valid=1 from R+1.
- DONE: wb_valid=1; wb_rd/wb_data held stable until wb_ready=1, then go IDLE. Backpressure is unbounded.
- flush:
  - In START or WAIT: go DRAIN; no writeback is produced.
  - In DONE: drop the result, go IDLE.
  - In IDLE: suppresses acceptance that cycle.
  - Simultaneous flush and RDY in WAIT: flush wins (go IDLE directly, nothing written).
- DRAIN: wait for md_resultRDY or timeout, discarding the result, then go IDLE. Counter continues from its WAIT value. Required because the unit cannot be aborted.
- At most one op in flight. md_ctrl_* never both high; never high outside START.
- Outputs are registered. wb_valid is low in every state except DONE.

Decomposition:
- Shared package: state encoding constants, OP_MULT/OP_DIV, default EXC codes, STATUS_REG.
- One natural sub-module: md_timeout_counter (clear, enable, terminal-count flag at TIMEOUT-1). Width = clog2(TIMEOUT).
- Everything else stays in one FSM.

Test Plan:
- Multiply: req MULT a=6 b=7 rd=5; behavioural unit raises RDY 32 cycles after start -> exactly one md_ctrl_MULT pulse, then wb_valid with wb_rd=5, wb_data=42; req_ready returns 1 after wb_ready.
- Divide by zero: req DIV a=100 b=0 rd=8; unit returns exception -> wb_rd=30, wb_data=5. Also DIV 100/7 rd=8 -> wb_data=14.
- Backpressure: wb_ready held 0 for 10 cycles after result -> wb_valid, wb_rd and wb_data stable throughout; req_valid ignored (req_ready=0).
- Flush: flush during WAIT cycle 5 -> state DRAIN, no wb_valid ever; RDY at cycle 32 -> IDLE next cycle; a new MULT 3*3 then returns 9.
- Timeout: unit never asserts RDY on MULT -> after TIMEOUT cycles, wb_rd=30, wb_data=4. Repeat with flush asserted -> IDLE, no writeback.
- Reset mid-WAIT: reset pulsed low at cycle 10 -> all outputs at reset values immediately; a stale RDY at cycle 32 produces no wb_valid.
